// File: rtl/shifter_right_seq_if.sv
// Start/done handshake bundle for the sequential right shifter.
// master drives start/dataA/dataB/Signal; slave returns busy/done/dataOut.
interface shifter_right_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output start, dataA, dataB, Signal,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output busy, done, dataOut
  );
endinterface

// File: rtl/shifter_right_seq.sv
// Multi-cycle log right shifter (SRL/SRA), one binary stage per cycle.
// Ports: clk, rst_n (async low), bus (slave: start/dataA/dataB/Signal in;
// busy/done/dataOut out). Macro SHIFTER_SRA_EN enables arithmetic fill.
module shifter_right_seq #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] SRL_CODE = 6'b000010,
  parameter logic [5:0] SRA_CODE = 6'b000011
) (
  input  logic                clk,
  input  logic                rst_n,
  shifter_right_seq_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_n;
  logic [4:0]       r_amt;
  logic [4:0]       w_amt_n;
  logic [2:0]       r_k;
  logic [2:0]       w_k_n;
  logic             r_sra;
  logic             w_sra_n;
  logic             r_done;
  logic             w_done_n;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_n;

  logic             w_fill;
  logic             w_mode;
  logic [5:0]       w_dist;
  logic [2*WIDTH-1:0] w_wide;
  logic [WIDTH-1:0] w_stage;
  logic             w_unused;

`ifdef SHIFTER_SRA_EN
  assign w_mode   = (bus.Signal == SRA_CODE);
  assign w_fill   = r_sra & r_acc[WIDTH-1];
  assign w_unused = ^{bus.dataB[WIDTH-1:5],
                      (bus.Signal == SRL_CODE)};
`else
  // Every opcode runs as SRL; mode flag stays 0.
  assign w_mode   = 1'b0;
  assign w_fill   = 1'b0;
  assign w_unused = ^{bus.dataB[WIDTH-1:5], r_sra,
                      (bus.Signal == SRL_CODE),
                      (bus.Signal == SRA_CODE)};
`endif

  // Fill word on top of the accumulator; shifting the pair by
  // 2^k leaves fill bits in the vacated MSBs of the low half.
  assign w_dist  = 6'd1 << r_k;
  assign w_wide  = {{WIDTH{w_fill}}, r_acc} >> w_dist;
  assign w_stage = r_amt[r_k] ? w_wide[WIDTH-1:0] : r_acc;

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_amt_n   = r_amt;
    w_k_n     = r_k;
    w_sra_n   = r_sra;
    w_done_n  = 1'b0;
    w_dout_n  = r_dout;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_acc_n   = bus.dataA;
          w_amt_n   = bus.dataB[4:0];
          w_sra_n   = w_mode;
          w_k_n     = 3'd0;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_acc_n = w_stage;
        w_k_n   = r_k + 3'd1;
        if (r_k == 3'd4) begin
          w_dout_n  = w_stage;
          w_done_n  = 1'b1;
          w_k_n     = 3'd0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_amt   <= '0;
      r_k     <= '0;
      r_sra   <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_amt   <= w_amt_n;
      r_k     <= w_k_n;
      r_sra   <= w_sra_n;
      r_done  <= w_done_n;
      r_dout  <= w_dout_n;
    end
  end

  assign bus.busy    = (r_state == S_SHIFT);
  assign bus.done    = r_done;
  assign bus.dataOut = r_dout;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Directed bench for shifter_right_seq.
// Expected values are hand-computed per vector.
module tb_shifter_right_seq;

  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  shifter_right_seq_if bus ();

  shifter_right_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [5:0]  sig,
                     input logic [31:0] exp);
    int cyc;
    int bcnt;
    bit got;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dataA  = a;
    bus.dataB  = b;
    bus.Signal = sig;
    @(posedge clk);
    cyc  = 0;
    bcnt = 0;
    got  = 0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) bcnt++;
      if (bus.done) got = 1;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd6);
    check({tag, "_busy"}, 32'(bcnt), 32'd5);
    check({tag, "_out"}, bus.dataOut, exp);
  endtask

  initial begin
    int dcnt;
    int didx;
    int d1;
    int d2;
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.Signal = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_out", bus.dataOut, 32'h0);
    rst_n = 1'b1;

    run("srl31", 32'h80000000, 32'd31, SRL, 32'h00000001);
`ifdef SHIFTER_SRA_EN
    run("sra4", 32'h80000000, 32'd4, SRA, 32'hF8000000);
    run("sra16", 32'hDEADBEEF, 32'd16, SRA, 32'hFFFFDEAD);
    run("sra31", 32'hFFFFFFFF, 32'd31, SRA, 32'hFFFFFFFF);
`else
    run("sra4", 32'h80000000, 32'd4, SRA, 32'h08000000);
    run("sra16", 32'hDEADBEEF, 32'd16, SRA, 32'h0000DEAD);
    run("sra31", 32'hFFFFFFFF, 32'd31, SRA, 32'h00000001);
`endif
    run("amt0", 32'h12345678, 32'hFFFFFFE0, SRA, 32'h12345678);
    run("other", 32'h80000000, 32'd4, 6'h3F, 32'h08000000);
    run("srl5", 32'hF0F0F0F0, 32'd5, SRL, 32'h07878787);

    // start/operand changes during SHIFT are ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dataA  = 32'hFFFF0000;
    bus.dataB  = 32'd8;
    bus.Signal = SRL;
    @(posedge clk);
    dcnt = 0;
    didx = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.dataA = 32'hAAAAAAAA;
        bus.dataB = 32'd1;
      end
      if (i == 3) bus.dataB = 32'd2;
      if (bus.done) begin
        dcnt++;
        if (didx == 0) didx = i;
      end
    end
    check("ign_cnt", 32'(dcnt), 32'd1);
    check("ign_idx", 32'(didx), 32'd6);
    check("ign_out", bus.dataOut, 32'h00FFFF00);

    // reset mid-shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.dataA = 32'h0000FFFF;
    bus.dataB = 32'd1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_done", {31'd0, bus.done}, 32'd0);
    check("mrst_out", bus.dataOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    check("mrst_quiet", 32'(dcnt), 32'd0);

    // back-to-back
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dataA  = 32'h80000000;
    bus.dataB  = 32'd1;
    bus.Signal = SRA;
    @(posedge clk);
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = i;
`ifdef SHIFTER_SRA_EN
          check("b2b_1", bus.dataOut, 32'hC0000000);
`else
          check("b2b_1", bus.dataOut, 32'h40000000);
`endif
          bus.start  = 1'b1;
          bus.dataA  = 32'h000000F0;
          bus.dataB  = 32'd4;
          bus.Signal = SRL;
        end else if (d2 == 0) begin
          d2 = i;
          check("b2b_2", bus.dataOut, 32'h0000000F);
        end
      end
    end
    check("b2b_idx1", 32'(d1), 32'd6);
    check("b2b_gap", 32'(d2 - d1), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_right_seq.md
# shifter_right_seq

Multi-cycle logarithmic right shifter for the ALU: the right-shift complement to the combinational left shifter. Executes SRL and SRA one binary stage per cycle (shift by 1, 2, 4, 8, 16) under a start/done handshake, trading latency for area and a short critical path. It sits beside the ALU's combinational units. The pipeline controller stalls on `busy` and captures `dataOut` on `done`.

## Interface
- `WIDTH`, 32: datapath width. Fixed at 32; the stage count is 5.
- `SRL_CODE`, 6'b000010: `Signal` value selecting logical right shift.
- `SRA_CODE`, 6'b000011: `Signal` value selecting arithmetic right shift.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `dataA`  in  32  operand to shift.
- `dataB`  in  32  shift amount; only `dataB[4:0]` (s4..s0) is used.
- `Signal`  in  6  operation code.
- `busy`  out  1  high while a shift is in progress.
- `done`  out  1  one-cycle pulse when `dataOut` is updated.
- `dataOut`  out  32  result register; holds its value until the next completion.

## Operation
- States: IDLE, SHIFT.
- IDLE with `start`=1 at an edge:
  - latch `dataA` into the accumulator and `dataB[4:0]` into the amount register;
  - latch the mode: arithmetic if `Signal`==`SRA_CODE`, otherwise logical;
  - stage counter k=0; go to SHIFT; `busy`=1.
- SHIFT, each edge:
  - if amount[k]=1, accumulator = accumulator >> 2^k;
  - vacated MSBs are filled with 0 (logical) or with the latched sign bit, accumulator[31] (arithmetic);
  - k increments by 1.
- SHIFT at the edge where k=4:
  - write the stage result into `dataOut`;
  - `done` asserts for the next cycle; `busy` drops; return to IDLE.
- Any `Signal` other than `SRA_CODE` executes as SRL. No error is flagged.
- `start` while `busy`=1 is ignored and is not queued.
- Inputs are only sampled on the accepting edge. Changes to `dataA`, `dataB` or `Signal` during SHIFT have no effect.
- Amount 0 still takes the full 5 stages, and the result equals `dataA`.
- `rst_n` low at any time, including mid-shift:
  - immediately forces IDLE with `busy`=0, `done`=0, `dataOut`=0;
  - accumulator, amount register and counter are cleared;
  - the in-flight operation is discarded and no `done` follows.

## Timing
- Reset values: `busy`=0, `done`=0, `dataOut`=32'h0.
- Accept edge E0; stages execute at E1..E5. `dataOut` is valid and `done`=1 in the cycle after E5.
- Latency is 5 cycles from the accepting edge to `done`.
- `busy`=1 for exactly 5 cycles, from after E0 until after E5.
- `done` and `busy` are never high together.
- Back-to-back: `start` held high in the `done` cycle is accepted at that edge. Sustained throughput is one result per 6 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `SHIFTER_SRA_EN` defined: arithmetic mode is implemented as described above.
- `SHIFTER_SRA_EN` undefined:
  - sign-fill logic is compiled out and every operation, including `SRA_CODE`, executes as SRL;
  - the interface is unchanged.

## Test plan
- Reset, then `start` with `dataA`=32'h80000000, `dataB`=31, `Signal`=SRL_CODE -> `done` 5 cycles after acceptance, `dataOut`=32'h00000001.
- `dataA`=32'h80000000, `dataB`=4, `Signal`=SRA_CODE -> `dataOut`=32'hF8000000 with the macro defined; 32'h08000000 with it undefined.
- `dataA`=32'h12345678, `dataB`=32'hFFFFFFE0 (amount 0), SRA -> `dataOut`=32'h12345678 after the full 5-cycle latency.
- Start a shift of 32'hFFFF0000 by 8 (SRL). Pulse `start` with new operands at cycle 2, and change `dataB` at cycle 3 -> both ignored; result 32'h00FFFF00; exactly one `done`.
- Pull `rst_n` low at cycle 3 of a shift -> `busy`, `done` and `dataOut` go to 0 immediately. After release, no `done` appears until a new `start`.
- Back-to-back: SRA 32'h80000000 by 1, then with `start` high in the `done` cycle, SRL 32'h000000F0 by 4 -> `dataOut`=32'hC0000000, then 32'h0000000F, with `done` pulses 6 cycles apart.
